rv_mdu_ctrl: RTL and testbench

//  Sequencer for the multi-cycle multiply/divide datapath in EX. Accepts an MDU request from decode
//  (decode_ex_mdu_req_o + decode_mdu_operation_o), stalls the pipeline, steps the datapath with a

---
 rtl/rv_mdu_ctrl_if.sv | 35 +++
 rtl/rv_mdu_ctrl.sv | 136 +++++++++++++
 tb/tb_rv_mdu_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mdu_ctrl_if.sv
//============================================================================
// rv_mdu_ctrl_if : decode/EX request bundle and MDU sequencer control outputs
// Rev 1.0
//============================================================================
`default_nettype none

interface rv_mdu_ctrl_if #(
  parameter int XLEN     = 32,
  parameter int MDU_OP_W = 3
);
  logic                mdu_req_i;
  logic [MDU_OP_W-1:0] mdu_op_i;
  logic [XLEN-1:0]     mdu_port1_i;
  logic [XLEN-1:0]     mdu_port2_i;
  logic                kill_i;

  logic                mdu_start_o;
  logic                mdu_step_o;
  logic [MDU_OP_W-1:0] mdu_op_o;
  logic [1:0]          mdu_special_o;
  logic                mdu_stall_o;
  logic                mdu_done_o;

  modport master (
    output mdu_req_i, mdu_op_i, mdu_port1_i, mdu_port2_i, kill_i,
    input  mdu_start_o, mdu_step_o, mdu_op_o, mdu_special_o, mdu_stall_o, mdu_done_o
  );

  modport slave (
    input  mdu_req_i, mdu_op_i, mdu_port1_i, mdu_port2_i, kill_i,
    output mdu_start_o, mdu_step_o, mdu_op_o, mdu_special_o, mdu_stall_o, mdu_done_o
  );
endinterface

`default_nettype wire

// File: rtl/rv_mdu_ctrl.sv
//============================================================================
// rv_mdu_ctrl : multi-cycle multiply/divide sequencer (accept, step, done)
// Rev 1.0
//============================================================================
`default_nettype none

module rv_mdu_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int XLEN       = 32,
  parameter int MDU_OP_W   = 3
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  rv_mdu_ctrl_if.slave  mdu
);

  // Operation encoding follows the RV32M funct3 field
  localparam logic [MDU_OP_W-1:0] MDU_MUL  = MDU_OP_W'(0);
  localparam logic [MDU_OP_W-1:0] MDU_DIV  = MDU_OP_W'(4);
  localparam logic [MDU_OP_W-1:0] MDU_DIVU = MDU_OP_W'(5);
  localparam logic [MDU_OP_W-1:0] MDU_REM  = MDU_OP_W'(6);
  localparam logic [MDU_OP_W-1:0] MDU_REMU = MDU_OP_W'(7);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0]      SPC_NONE = 2'b00;
  localparam logic [1:0]      SPC_DIV0 = 2'b01;
  localparam logic [1:0]      SPC_OVFL = 2'b10;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [1:0]          special_q, special_d;

  logic start, step, stall, done;
  logic is_div, is_sdiv, div_zero, overflow;

  assign is_div   = mdu.mdu_op_i inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  assign is_sdiv  = mdu.mdu_op_i inside {MDU_DIV, MDU_REM};
  assign div_zero = (mdu.mdu_port2_i == '0);
  assign overflow = is_sdiv && (mdu.mdu_port1_i == INT_MIN) && (mdu.mdu_port2_i == '1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= MDU_MUL;
      special_q <= SPC_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      special_q <= special_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    special_d = special_q;
    start     = 1'b0;
    step      = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;

    // Flush wins everywhere; op/special deliberately survive it
    if (mdu.kill_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Gating with reset keeps start low while the async reset is held
          if (mdu.mdu_req_i && !rst_i) begin
            start = 1'b1;
            stall = 1'b1;
            op_d  = mdu.mdu_op_i;
            if (is_div && div_zero) begin
              state_d   = S_DONE;
              cnt_d     = '0;
              special_d = SPC_DIV0;
            end else if (overflow) begin
              state_d   = S_DONE;
              cnt_d     = '0;
              special_d = SPC_OVFL;
            end else if (is_div) begin
              state_d   = S_DIV;
              cnt_d     = CNT_W'(DIV_CYCLES);
              special_d = SPC_NONE;
            end else begin
              state_d   = S_MUL;
              cnt_d     = CNT_W'(MUL_CYCLES);
              special_d = SPC_NONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          step  = 1'b1;
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign mdu.mdu_start_o   = start;
  assign mdu.mdu_step_o    = step;
  assign mdu.mdu_stall_o   = stall;
  assign mdu.mdu_done_o    = done;
  assign mdu.mdu_op_o      = op_q;
  assign mdu.mdu_special_o = special_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_mdu_ctrl.sv
//============================================================================
// tb_rv_mdu_ctrl : vector table, directed corner sequences and random ops
// Rev 1.0
//============================================================================
`default_nettype none

module tb_rv_mdu_ctrl;

  localparam int MUL_CYC = 2;
  localparam int DIV_CYC = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rv_mdu_ctrl_if #(.XLEN(32), .MDU_OP_W(3)) bus ();

  rv_mdu_ctrl #(
    .MUL_CYCLES (MUL_CYC),
    .DIV_CYCLES (DIV_CYC),
    .XLEN       (32),
    .MDU_OP_W   (3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    int         lat;
    int         steps;
    logic [1:0] special;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: latency/steps/special purely from the operation's arithmetic meaning
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output int steps, output logic [1:0] sp);
    bit div_op = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    bit signed_div = (op == OP_DIV) || (op == OP_REM);
    if (div_op && b == 32'd0) begin
      lat = 1; steps = 0; sp = 2'b01;
    end else if (signed_div && $signed(a) == -32'sd2147483648 && $signed(b) == -32'sd1) begin
      lat = 1; steps = 0; sp = 2'b10;
    end else begin
      steps = div_op ? DIV_CYC : MUL_CYC;
      lat   = steps + 1;
      sp    = 2'b00;
    end
  endfunction

  // Starts at posedge+1 of the accept cycle; returns at posedge+1 of the cycle after done
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit hold, input int exp_lat,
                        input int exp_steps, input logic [1:0] exp_sp);
    int lat = -1;
    int steps = 0;
    int starts = 0;
    int late_start = 0;
    int stall_gap = 0;
    logic [1:0] sp = 2'bxx;
    logic [2:0] opo = 3'bxxx;
    bus.mdu_req_i   = 1'b1;
    bus.mdu_op_i    = op;
    bus.mdu_port1_i = a;
    bus.mdu_port2_i = b;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.mdu_start_o) begin
        starts++;
        if (c != 0) late_start++;
      end
      if (bus.mdu_step_o) steps++;
      if (bus.mdu_done_o) begin
        lat = c;
        sp  = bus.mdu_special_o;
        opo = bus.mdu_op_o;
        if (bus.mdu_stall_o) stall_gap++;
      end else if (!bus.mdu_stall_o) begin
        stall_gap++;
      end
      @(posedge clk);
      #1;
      if (lat >= 0) break;
    end
    if (!hold) bus.mdu_req_i = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_steps"}, 64'(steps), 64'(exp_steps));
    check({name, "_special"}, 64'(sp), 64'(exp_sp));
    check({name, "_op_out"}, 64'(opo), 64'(op));
    check({name, "_start_once_at_accept"}, 64'(starts * 10 + late_start), 64'd10);
    check({name, "_stall_window"}, 64'(stall_gap), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[9];

  initial begin
    int cnt;
    int lat, steps;
    logic [1:0] sp;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{"mul",        OP_MUL,    32'd3,         32'd5,         3,  2,  2'b00};
    vecs[1] = '{"mulhu",      OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,  2,  2'b00};
    vecs[2] = '{"mulh_min",   OP_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 3,  2,  2'b00};
    vecs[3] = '{"divu_100_7", OP_DIVU,   32'd100,       32'd7,         33, 32, 2'b00};
    vecs[4] = '{"div_by0",    OP_DIV,    32'd42,        32'd0,         1,  0,  2'b01};
    vecs[5] = '{"remu_by0",   OP_REMU,   32'd9,         32'd0,         1,  0,  2'b01};
    vecs[6] = '{"div_ovfl",   OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1,  0,  2'b10};
    vecs[7] = '{"rem_ovfl",   OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1,  0,  2'b10};
    vecs[8] = '{"divu_nosc",  OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32, 2'b00};

    bus.mdu_req_i   = 1'b1;
    bus.mdu_op_i    = OP_DIV;
    bus.mdu_port1_i = 32'd1;
    bus.mdu_port2_i = 32'd0;
    bus.kill_i      = 1'b0;

    // Reset values while reset is held, even with a request pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start", 64'(bus.mdu_start_o), 64'd0);
    check("rst_step",  64'(bus.mdu_step_o),  64'd0);
    check("rst_stall", 64'(bus.mdu_stall_o), 64'd0);
    check("rst_done",  64'(bus.mdu_done_o),  64'd0);
    check("rst_op",    64'(bus.mdu_op_o),    64'(OP_MUL));
    check("rst_spc",   64'(bus.mdu_special_o), 64'd0);
    bus.mdu_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
             vecs[i].lat, vecs[i].steps, vecs[i].special);
    end

    // op and special hold after done until the next accept
    run_op("div0_hold", OP_DIV, 32'd5, 32'd0, 1'b0, 1, 0, 2'b01);
    @(negedge clk);
    check("hold_special", 64'(bus.mdu_special_o), 64'd1);
    check("hold_op",      64'(bus.mdu_op_o),      64'(OP_DIV));
    check("idle_stall",   64'(bus.mdu_stall_o),   64'd0);
    check("idle_done",    64'(bus.mdu_done_o),    64'd0);
    @(posedge clk);
    #1;

    // Back-to-back MULs with request held: done@3, accept@4, done@7
    run_op("b2b_first",  OP_MUL, 32'd2, 32'd3, 1'b1, 3, 2, 2'b00);
    run_op("b2b_second", OP_MUL, 32'd4, 32'd5, 1'b0, 3, 2, 2'b00);

    // Kill at cycle 10 of a DIV, then a MUL accepted at cycle 11
    bus.mdu_req_i   = 1'b1;
    bus.mdu_op_i    = OP_DIV;
    bus.mdu_port1_i = 32'd100;
    bus.mdu_port2_i = 32'd7;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mdu_step_o) cnt++;
      if (bus.mdu_done_o) cnt += 100;
      @(posedge clk);
      #1;
    end
    check("kill_pre_steps", 64'(cnt), 64'd9);
    bus.kill_i = 1'b1;
    @(negedge clk);
    check("kill_step",  64'(bus.mdu_step_o),  64'd0);
    check("kill_stall", 64'(bus.mdu_stall_o), 64'd0);
    check("kill_done",  64'(bus.mdu_done_o),  64'd0);
    check("kill_op",    64'(bus.mdu_op_o),    64'(OP_DIV));
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    run_op("after_kill_mul", OP_MUL, 32'd6, 32'd7, 1'b0, 3, 2, 2'b00);

    // Kill together with a request in IDLE: no accept
    bus.mdu_req_i = 1'b1;
    bus.mdu_op_i  = OP_MULHSU;
    bus.kill_i    = 1'b1;
    @(negedge clk);
    check("idle_kill_start", 64'(bus.mdu_start_o), 64'd0);
    check("idle_kill_stall", 64'(bus.mdu_stall_o), 64'd0);
    @(posedge clk);
    #1;
    bus.kill_i    = 1'b0;
    bus.mdu_req_i = 1'b0;
    @(negedge clk);
    check("idle_kill_noop", 64'({bus.mdu_stall_o, bus.mdu_step_o, bus.mdu_done_o}), 64'd0);
    @(posedge clk);
    #1;

    // Async reset mid-DIV: reset values immediately, then normal operation
    bus.mdu_req_i   = 1'b1;
    bus.mdu_op_i    = OP_DIVU;
    bus.mdu_port1_i = 32'd77;
    bus.mdu_port2_i = 32'd3;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_step",  64'(bus.mdu_step_o),  64'd0);
    check("midrst_stall", 64'(bus.mdu_stall_o), 64'd0);
    check("midrst_start", 64'(bus.mdu_start_o), 64'd0);
    check("midrst_done",  64'(bus.mdu_done_o),  64'd0);
    check("midrst_op",    64'(bus.mdu_op_o),    64'(OP_MUL));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mdu_req_i = 1'b0;
    run_op("after_rst_mul", OP_MULH, 32'd1, 32'd1, 1'b0, 3, 2, 2'b00);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      model(rop, ra, rb, lat, steps, sp);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b0, lat, steps, sp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
